// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit sequencer between the EX stage and a req/gnt + rvalid memory bus.
// Latency: store 2 cycles accept->done (gnt in first REQ cycle), load 3 (rvalid right after gnt), fault 1.
// Backpressure: lsu_stall holds the pipeline while a request waits on bus_gnt/bus_rvalid; BUS_TIMEOUT bounds the wait.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   ex_valid, mem_rd_en, mem_wr_en    EX-stage access request and direction
//   mem_funct3, alu_res, rs2_data     access size/sign, byte address, store data
//   lsu_stall, lsu_done, lsu_rdata,   pipeline freeze, completion pulse, extended load data,
//   lsu_err                           fault flag (meaningful only with lsu_done)
//   bus_req/we/addr/wdata/wstrb       memory request channel (word aligned)
//   bus_gnt, bus_rvalid, bus_rdata    memory response channel
module lsu_ctrl #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] alu_res,
  input  logic [31:0] rs2_data,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int CNT_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
  // Abort is taken on the edge where the counter reaches BUS_TIMEOUT, so the
  // decision is made while it still holds BUS_TIMEOUT-1.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(BUS_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic        accept;
  logic        bad_acc;
  logic        timeout;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] st_data;
  logic [3:0]  st_strb;

  assign accept = ex_valid & (mem_rd_en | mem_wr_en);

  // Faults are decided from the live inputs so the access never reaches the bus.
  assign bad_acc = (mem_rd_en & mem_wr_en)
                 | (mem_funct3 == 3'b011)
                 | (mem_funct3[2:1] == 2'b11)
                 | (mem_funct3[2] & mem_wr_en)
                 | ((mem_funct3[1:0] == 2'b01) & alu_res[0])
                 | ((mem_funct3 == 3'b010) & (alu_res[1:0] != 2'b00));

  // >= rather than == so a load granted on its last budget cycle still aborts
  // one cycle later instead of waiting for the counter to wrap.
  assign timeout = (cnt_q >= TO_LAST);

  always_comb begin
    ld_byte = bus_rdata[7:0];
    case (addr_q[1:0])
      2'b01:   ld_byte = bus_rdata[15:8];
      2'b10:   ld_byte = bus_rdata[23:16];
      2'b11:   ld_byte = bus_rdata[31:24];
      default: ld_byte = bus_rdata[7:0];
    endcase
    ld_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    // funct3[2] marks the unsigned variants.
    case (f3_q[1:0])
      2'b00:   ld_data = {{24{ld_byte[7] & ~f3_q[2]}}, ld_byte};
      2'b01:   ld_data = {{16{ld_half[15] & ~f3_q[2]}}, ld_half};
      default: ld_data = bus_rdata;
    endcase
  end

  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        st_strb = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << {addr_q[1], 1'b0};
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = alu_res;
          wdata_d = rs2_data;
          f3_d    = mem_funct3;
          we_d    = mem_wr_en;
          cnt_d   = '0;
          if (bad_acc) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_gnt) begin
          if (we_q) begin
            state_d = DONE;
            err_d   = 1'b0;
            rdata_d = '0;
          end else begin
            state_d = WAIT_R;
          end
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      WAIT_R: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_rvalid) begin
          state_d = DONE;
          err_d   = 1'b0;
          rdata_d = ld_data;
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are forced low while rst is high, even before the first reset edge.
  assign bus_req   = ~rst & (state_q == REQ);
  assign bus_we    = bus_req & we_q;
  assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus_wdata = bus_we ? st_data : 32'd0;
  assign bus_wstrb = bus_we ? st_strb : 4'd0;
  assign lsu_stall = ~rst & (((state_q == IDLE) & accept) | (state_q == REQ) | (state_q == WAIT_R));
  assign lsu_done  = ~rst & (state_q == DONE);
  assign lsu_err   = lsu_done & err_q;
  assign lsu_rdata = rst ? 32'd0 : rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, mem_rd_en = 1'b0, mem_wr_en = 1'b0;
  logic [2:0]  mem_funct3 = 3'd0;
  logic [31:0] alu_res = 32'd0, rs2_data = 32'd0;
  logic        lsu_stall, lsu_done, lsu_err;
  logic [31:0] lsu_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  lsu_ctrl #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_funct3(mem_funct3), .alu_res(alu_res), .rs2_data(rs2_data),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } done_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_exp_t;

  done_exp_t exp_done[$];
  bus_exp_t  exp_bus[$];

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int req_cycles = 0;

  int          gnt_dly = 0;
  int          rv_dly = 0;
  logic [31:0] rsp_data = 32'd0;
  bit          spur = 0;
  bit          late_kick = 0;
  int          req_wait = 0;
  int          rv_cnt = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus responder: grant after gnt_dly REQ cycles, rvalid rv_dly cycles after a load grant.
  always @(posedge clk) begin
    #2;
    bus_gnt = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata = 32'd0;
    if (rv_cnt == 0) begin
      bus_rvalid = 1'b1;
      bus_rdata = rsp_data;
      rv_cnt = -1;
    end else if (rv_cnt > 0) begin
      rv_cnt--;
    end
    if (bus_req) begin
      if (spur && !bus_rvalid) begin
        bus_rvalid = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
      end
      if (gnt_dly >= 0 && req_wait == gnt_dly) begin
        bus_gnt = 1'b1;
        if (!bus_we) rv_cnt = rv_dly;
      end
      req_wait++;
    end else begin
      req_wait = 0;
    end
    if (late_kick) begin
      bus_gnt = 1'b1;
      bus_rvalid = 1'b1;
      bus_rdata = 32'hFFFF_FFFF;
    end
  end

  // Monitor: compare whatever the DUT presents against the head of the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_req) begin
        req_cycles++;
        if (exp_bus.size() == 0) begin
          chk("bus_req_unexpected", 32'd1, 32'd0);
        end else begin
          chk("bus_addr", bus_addr, exp_bus[0].addr);
          chk("bus_we", {31'd0, bus_we}, {31'd0, exp_bus[0].we});
          if (exp_bus[0].we) begin
            chk("bus_wdata", bus_wdata, exp_bus[0].wdata);
            chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, exp_bus[0].wstrb});
          end
          if (bus_gnt) void'(exp_bus.pop_front());
        end
      end
      if (lsu_done) begin
        if (exp_done.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          done_exp_t e;
          e = exp_done.pop_front();
          chk("lsu_rdata", lsu_rdata, e.rdata);
          chk("lsu_err", {31'd0, lsu_err}, {31'd0, e.err});
          chk("done_cycle", cyc, e.cyc);
          chk("stall_in_done", {31'd0, lsu_stall}, 32'd0);
        end
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_bus(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] ws);
    bus_exp_t b;
    b.addr = a; b.we = we; b.wdata = wd; b.wstrb = ws;
    exp_bus.push_back(b);
  endtask

  // One access: drive for one accept cycle (plus hold), then wait for the expected done.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int gd, input int rvd, input logic [31:0] rsp,
                        input logic [31:0] exp_rd, input logic exp_err, input int lat,
                        input bit hold);
    done_exp_t e;
    int n;
    gnt_dly = gd; rv_dly = rvd; rsp_data = rsp;
    e.rdata = exp_rd; e.err = exp_err; e.cyc = cyc + lat;
    exp_done.push_back(e);
    ex_valid = 1'b1; mem_rd_en = rd; mem_wr_en = wr; mem_funct3 = f3;
    alu_res = addr; rs2_data = wd;
    @(negedge clk);
    chk("stall_on_accept", {31'd0, lsu_stall}, 32'd1);
    step(1);
    if (hold) step(1);
    ex_valid = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
    n = 0;
    while (exp_done.size() != 0 && n < 30) begin
      step(1);
      n++;
    end
    if (exp_done.size() != 0) begin
      chk("done_wait_expired", 32'd0, 32'd1);
      exp_done.delete();
    end
    step(1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_req"}, {31'd0, bus_req}, 32'd0);
    chk({tag, "_bus_we"}, {31'd0, bus_we}, 32'd0);
    chk({tag, "_bus_addr"}, bus_addr, 32'd0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_bus_wstrb"}, {28'd0, bus_wstrb}, 32'd0);
    chk({tag, "_stall"}, {31'd0, lsu_stall}, 32'd0);
    chk({tag, "_done"}, {31'd0, lsu_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, lsu_err}, 32'd0);
    chk({tag, "_rdata"}, lsu_rdata, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rq0;
    // Reset, with a load offered that must not be accepted.
    ex_valid = 1'b1; mem_rd_en = 1'b1; mem_funct3 = 3'b010;
    @(negedge clk);
    chk_all_zero("rst");
    step(1);
    ex_valid = 1'b0; mem_rd_en = 1'b0;
    @(negedge clk);
    chk_all_zero("rst2");
    step(1);
    rst = 1'b0;
    step(1);

    // LB 0x103 -> byte 3 of 0x80FF0000, sign extended.
    push_bus(32'h100, 1'b0, 32'd0, 4'd0);
    access(1, 0, 3'b000, 32'h103, 32'd0, 0, 0, 32'h80FF_0000, 32'hFFFF_FF80, 1'b0, 3, 0);

    // SH 0x202.
    push_bus(32'h200, 1'b1, 32'hABCD_ABCD, 4'b1100);
    access(0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 0, 0, 32'd0, 32'd0, 1'b0, 2, 0);

    // LW 0x101 misaligned, ex_valid held through DONE: one fault, no bus cycle.
    rq0 = req_cycles;
    access(1, 0, 3'b010, 32'h101, 32'd0, 0, 0, 32'd0, 32'd0, 1'b1, 1, 1);
    chk("misalign_no_req", req_cycles - rq0, 32'd0);

    // SW with no grant: 4 request cycles then timeout fault; late gnt/rvalid ignored.
    rq0 = req_cycles;
    push_bus(32'h300, 1'b1, 32'hCAFE_F00D, 4'b1111);
    access(0, 1, 3'b010, 32'h300, 32'hCAFE_F00D, -1, -1, 32'd0, 32'd0, 1'b1, 5, 0);
    exp_bus.delete();
    late_kick = 1'b1;
    step(1);
    late_kick = 1'b0;
    step(2);
    chk("timeout_req_cycles", req_cycles - rq0, 32'd4);
    @(negedge clk);
    chk("late_rdata_held", lsu_rdata, 32'd0);
    chk("late_no_stall", {31'd0, lsu_stall}, 32'd0);
    step(1);

    // LBU 0x101 with spurious rvalid during REQ and grant on the 2nd cycle.
    spur = 1'b1;
    push_bus(32'h100, 1'b0, 32'd0, 4'd0);
    access(1, 0, 3'b100, 32'h101, 32'd0, 1, 0, 32'h0000_F000, 32'h0000_00F0, 1'b0, 4, 0);
    spur = 1'b0;

    // LH / LHU at 0x002 from the upper halfword.
    push_bus(32'h0, 1'b0, 32'd0, 4'd0);
    access(1, 0, 3'b001, 32'h002, 32'd0, 0, 0, 32'h8001_7FFF, 32'hFFFF_8001, 1'b0, 3, 0);
    push_bus(32'h0, 1'b0, 32'd0, 4'd0);
    access(1, 0, 3'b101, 32'h002, 32'd0, 0, 0, 32'h8001_7FFF, 32'h0000_8001, 1'b0, 3, 0);

    // LHU 0x2, grant on the 3rd REQ cycle, reset while in WAIT_R.
    gnt_dly = 2; rv_dly = -1;
    push_bus(32'h0, 1'b0, 32'd0, 4'd0);
    ex_valid = 1'b1; mem_rd_en = 1'b1; mem_funct3 = 3'b101; alu_res = 32'h2;
    step(1);
    ex_valid = 1'b0; mem_rd_en = 1'b0;
    step(3);
    chk("waitr_stall", {31'd0, lsu_stall}, 32'd1);
    chk("waitr_no_req", {31'd0, bus_req}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    step(1);
    @(negedge clk);
    chk_all_zero("midrst2");
    step(1);
    rst = 1'b0;
    step(3);
    chk("midrst_bus_q", exp_bus.size(), 32'd0);
    chk("midrst_done_q", exp_done.size(), 32'd0);
    chk("midrst_stall", {31'd0, lsu_stall}, 32'd0);

    // SB 0x005, SW 0x008 with grant on the 2nd cycle.
    push_bus(32'h4, 1'b1, 32'hA5A5_A5A5, 4'b0010);
    access(0, 1, 3'b000, 32'h005, 32'h0000_00A5, 0, 0, 32'd0, 32'd0, 1'b0, 2, 0);
    push_bus(32'h8, 1'b1, 32'h1122_3344, 4'b1111);
    access(0, 1, 3'b010, 32'h008, 32'h1122_3344, 1, 0, 32'd0, 32'd0, 1'b0, 3, 0);

    // Good LW, then illegal accesses (each clears lsu_rdata, no bus cycle).
    push_bus(32'h10, 1'b0, 32'd0, 4'd0);
    access(1, 0, 3'b010, 32'h010, 32'd0, 0, 0, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0, 3, 0);
    rq0 = req_cycles;
    access(0, 1, 3'b100, 32'h000, 32'd0, 0, 0, 32'd0, 32'd0, 1'b1, 1, 0);
    access(1, 1, 3'b010, 32'h000, 32'd0, 0, 0, 32'd0, 32'd0, 1'b1, 1, 0);
    access(1, 0, 3'b011, 32'h000, 32'd0, 0, 0, 32'd0, 32'd0, 1'b1, 1, 0);
    access(1, 0, 3'b110, 32'h000, 32'd0, 0, 0, 32'd0, 32'd0, 1'b1, 1, 0);
    access(0, 1, 3'b001, 32'h001, 32'd0, 0, 0, 32'd0, 32'd0, 1'b1, 1, 0);
    access(1, 0, 3'b101, 32'h003, 32'd0, 0, 0, 32'd0, 32'd0, 1'b1, 1, 0);
    chk("illegal_no_req", req_cycles - rq0, 32'd0);

    // LW 0x20 granted at once but no rvalid: timeout in WAIT_R.
    push_bus(32'h20, 1'b0, 32'd0, 4'd0);
    access(1, 0, 3'b010, 32'h020, 32'd0, 0, -1, 32'd0, 32'd0, 1'b1, 5, 0);

    step(2);
    chk("end_bus_q", exp_bus.size(), 32'd0);
    chk("end_done_q", exp_done.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
